// File: rtl/noc_router_in.sv
// -----------------------------------------------------------------------------
// noc_router_in
//
// Input unit of the 4-node NoC router. Incoming 8-bit flits from the processor
// network interface are buffered in a small FIFO. The flit at the FIFO head is
// checked as a packet header. Each packet of FLITS_PER_PKT flits (header, data,
// tail) is then steered wormhole-style to one of four output ports. The port is
// picked by the header's 2-bit destination field and held until the tail flit
// has been accepted.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   flit_in        flit from the upstream network interface
//   flit_in_valid  flit_in is valid
//   flit_in_ready  a flit can be accepted this cycle (FIFO not full)
//   out_flit       FIFO head, shared bus to all output ports
//   out_valid      one-hot valid; bit i means out_flit targets output port i
//   out_ready      per-port ready from the output arbiters
//   busy           packet in flight (after header accept, up to tail accept)
//   err_hdr        one-cycle pulse while a malformed header flit is discarded
//   pkt_count      number of completed packets, wraps at 16'hFFFF -> 0
// -----------------------------------------------------------------------------
module noc_router_in #(
    parameter int         DEPTH         = 8,
    parameter logic [5:0] HEADER        = 6'b111111,
    parameter int         FLITS_PER_PKT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  flit_in,
    input  logic        flit_in_valid,
    output logic        flit_in_ready,
    output logic [7:0]  out_flit,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready,
    output logic        busy,
    output logic        err_hdr,
    output logic [15:0] pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FLITS_PER_PKT);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TAIL_IDX = CW'(FLITS_PER_PKT - 1);

    typedef enum logic {
        ST_HEAD,
        ST_BODY
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    state_t        state_q,  state_d;
    logic [1:0]    port_q,   port_d;
    logic [CW-1:0] flit_cnt_q, flit_cnt_d;
    logic [15:0]   pkt_count_q, pkt_count_d;

    // -------------------------------------------------------------------------
    // FIFO status and handshakes
    // -------------------------------------------------------------------------
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       accept;
    logic       discard;
    logic       hdr_ok;
    logic [7:0] head_flit;

    assign full      = (count_q == FULL_LVL);
    assign empty     = (count_q == '0);
    assign head_flit = mem_q[rd_ptr_q];
    assign hdr_ok    = (head_flit[7:2] == HEADER);

    // Ready depends only on occupancy. A pop in the same cycle does not open a
    // slot for a push while the FIFO is full.
    assign flit_in_ready = !full;
    assign push          = flit_in_valid && !full;

    // A flit leaves the FIFO when the selected port takes it, or when a bad
    // header is dropped.
    assign accept = |(out_valid & out_ready);
    assign pop    = accept || discard;

    assign out_flit  = head_flit;
    assign busy      = (state_q == ST_BODY);
    assign pkt_count = pkt_count_q;

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Occupancy and pointers define which
    // entries are live, so resetting the data only adds reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_in;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers / occupancy
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at the
    // top. A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Routing FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        flit_cnt_d  = flit_cnt_q;
        pkt_count_d = pkt_count_q;
        unique case (state_q)
            ST_HEAD: begin
                // While a good header waits at the head, the latch follows its
                // destination field. It is therefore already correct when the
                // header is accepted.
                if (!empty && hdr_ok) begin
                    port_d = head_flit[1:0];
                end
                if (accept) begin
                    flit_cnt_d = CW'(1);
                    state_d    = ST_BODY;
                end
            end
            ST_BODY: begin
                // Data and tail flits are told apart by position alone. Payload
                // bytes that look like a header are forwarded unchanged.
                if (accept) begin
                    if (flit_cnt_q == TAIL_IDX) begin
                        flit_cnt_d  = '0;
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = ST_HEAD;
                    end else begin
                        flit_cnt_d = flit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_HEAD;
        endcase
    end

    // -------------------------------------------------------------------------
    // Routing FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid = '0;
        err_hdr   = 1'b0;
        discard   = 1'b0;
        unique case (state_q)
            ST_HEAD: begin
                if (!empty) begin
                    if (hdr_ok) begin
                        out_valid[head_flit[1:0]] = 1'b1;
                    end else begin
                        err_hdr = 1'b1;
                        discard = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (!empty) begin
                    out_valid[port_q] = 1'b1;
                end
            end
            default: begin
                out_valid = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Routing FSM and FIFO control: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops then
    // sample their _d values from before the edge, whatever order the blocks
    // are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_HEAD;
            port_q      <= '0;
            flit_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            port_q      <= port_d;
            flit_cnt_q  <= flit_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_noc_router_in.sv
// -----------------------------------------------------------------------------
// tb_noc_router_in
//
// Self-checking bench for noc_router_in. It runs four parts in order:
//   1. A table of per-cycle vectors: one packet, a malformed header, and a
//      second packet.
//   2. A full-FIFO stall sequence followed by an in-order drain.
//   3. An asynchronous reset in the middle of a packet.
//   4. Random traffic compared each cycle with a queue-based packet model.
// -----------------------------------------------------------------------------
module tb_noc_router_in;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  flit_in;
    logic        flit_in_valid;
    logic        flit_in_ready;
    logic [7:0]  out_flit;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;
    logic        err_hdr;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    noc_router_in #(
        .DEPTH        (8),
        .HEADER       (6'b111111),
        .FLITS_PER_PKT(6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .err_hdr      (err_hdr),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Observable outputs packed together. out_flit counts only while a valid is up.
    function automatic logic [30:0] obs(input logic r, input logic [3:0] v, input logic b,
                                        input logic e, input logic [15:0] p, input logic [7:0] f);
        return {r, v, b, e, p, (v != 4'b0000) ? f : 8'h00};
    endfunction

    // ---------------------------------------------------------------------
    // Vector table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0]  flit;
        logic        vld;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [7:0]  e_flit;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] f, input logic v, input logic [3:0] r,
                                input logic er, input logic [3:0] ev, input logic [7:0] ef,
                                input logic eb, input logic ee, input logic [15:0] ep);
        vec_t t;
        t.flit = f; t.vld = v; t.ordy = r; t.e_rdy = er; t.e_val = ev;
        t.e_flit = ef; t.e_busy = eb; t.e_err = ee; t.e_pkt = ep;
        return t;
    endfunction

    // ---------------------------------------------------------------------
    // Reference model: the FIFO as a queue plus packet position
    // ---------------------------------------------------------------------
    logic [7:0] m_fifo[$];
    bit         m_in_pkt;
    logic [1:0] m_port;
    int         m_idx;
    logic [15:0] m_pkt;

    task automatic model_reset();
        m_fifo.delete();
        m_in_pkt = 0;
        m_port   = 2'd0;
        m_idx    = 0;
        m_pkt    = 16'd0;
    endtask

    // ---------------------------------------------------------------------
    // Shared variables for the hand-written sequences
    // ---------------------------------------------------------------------
    logic [7:0] full_list[12];
    logic [7:0] rst_pkt[6];
    logic [7:0] src[$];
    int         n;
    int         got_cnt;
    int         acc;
    logic       rdy_s;

    initial begin
        rst           = 1'b1;
        flit_in       = 8'h00;
        flit_in_valid = 1'b0;
        out_ready     = 4'b0000;

        // Part 1: table of per-cycle vectors. Inputs are applied in a cycle and
        // the outputs are sampled in that same cycle, before the next edge.
        //               flit  vld ordy  rdy val      flit  busy err pkt
        vecs.push_back(mk(8'hFE, 1, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 16'd0)); // empty
        vecs.push_back(mk(8'hFF, 1, 4'hF, 1, 4'b0100, 8'hFE, 0, 0, 16'd0)); // header dest 2
        vecs.push_back(mk(8'hFC, 1, 4'hF, 1, 4'b0100, 8'hFF, 1, 0, 16'd0)); // FF payload
        vecs.push_back(mk(8'hDE, 1, 4'hF, 1, 4'b0100, 8'hFC, 1, 0, 16'd0)); // header-like payload
        vecs.push_back(mk(8'hAD, 1, 4'hF, 1, 4'b0100, 8'hDE, 1, 0, 16'd0));
        vecs.push_back(mk(8'hEF, 1, 4'hF, 1, 4'b0100, 8'hAD, 1, 0, 16'd0));
        vecs.push_back(mk(8'h00, 0, 4'hF, 1, 4'b0100, 8'hEF, 1, 0, 16'd0)); // tail
        vecs.push_back(mk(8'h3C, 1, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 16'd1));
        vecs.push_back(mk(8'hFC, 1, 4'hF, 1, 4'b0000, 8'h00, 0, 1, 16'd1)); // 3C dropped
        vecs.push_back(mk(8'h01, 1, 4'hF, 1, 4'b0001, 8'hFC, 0, 0, 16'd1)); // header dest 0
        vecs.push_back(mk(8'h02, 1, 4'hF, 1, 4'b0001, 8'h01, 1, 0, 16'd1));
        vecs.push_back(mk(8'h03, 1, 4'hF, 1, 4'b0001, 8'h02, 1, 0, 16'd1));
        vecs.push_back(mk(8'h04, 1, 4'hF, 1, 4'b0001, 8'h03, 1, 0, 16'd1));
        vecs.push_back(mk(8'h05, 1, 4'hF, 1, 4'b0001, 8'h04, 1, 0, 16'd1));
        vecs.push_back(mk(8'h00, 0, 4'hF, 1, 4'b0001, 8'h05, 1, 0, 16'd1)); // tail
        vecs.push_back(mk(8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 0, 0, 16'd2));

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", obs(flit_in_ready, out_valid, busy, err_hdr, pkt_count, out_flit),
              obs(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, 8'h00));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            flit_in       = vecs[i].flit;
            flit_in_valid = vecs[i].vld;
            out_ready     = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d", i),
                  obs(flit_in_ready, out_valid, busy, err_hdr, pkt_count, out_flit),
                  obs(vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_busy, vecs[i].e_err,
                      vecs[i].e_pkt, vecs[i].e_flit));
            @(posedge clk);
            @(negedge clk);
        end

        // Part 2: full FIFO. Two packets to port 1 arrive while port 1 is
        // stalled; ready bits on the other ports must not pop anything.
        full_list = '{8'hFD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                      8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        out_ready = 4'b1101;
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            flit_in_valid = (n < 12);
            flit_in       = (n < 12) ? full_list[n] : 8'h00;
            #1;
            rdy_s = flit_in_ready;
            @(posedge clk);
            if (flit_in_valid && rdy_s) n++;
            @(negedge clk);
        end
        #1;
        check("full_pushed", 64'(n), 64'd8);
        check("full_ready_low", {63'd0, flit_in_ready}, 64'd0);
        check("full_stall_head", obs(1'b0, out_valid, busy, err_hdr, pkt_count, out_flit),
              obs(1'b0, 4'b0010, 1'b0, 1'b0, 16'd2, 8'hFD));

        out_ready = 4'b0010;
        got_cnt   = 0;
        for (int cyc = 0; cyc < 60 && got_cnt < 12; cyc++) begin
            flit_in_valid = (n < 12);
            flit_in       = (n < 12) ? full_list[n] : 8'h00;
            #1;
            if ((out_valid & out_ready) != 4'b0000) begin
                check($sformatf("drain%0d", got_cnt), {52'd0, out_valid, out_flit},
                      {52'd0, 4'b0010, full_list[got_cnt]});
                got_cnt++;
            end
            rdy_s = flit_in_ready;
            @(posedge clk);
            if (flit_in_valid && rdy_s) n++;
            @(negedge clk);
        end
        flit_in_valid = 1'b0;
        #1;
        check("drain_count", 64'(got_cnt), 64'd12);
        check("drain_pkt_count", {48'd0, pkt_count}, 64'd4);
        @(negedge clk);

        // Part 3: asynchronous reset after three flits have gone out
        rst_pkt   = '{8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
        out_ready = 4'hF;
        n   = 0;
        acc = 0;
        for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
            flit_in_valid = (n < 6);
            flit_in       = (n < 6) ? rst_pkt[n] : 8'h00;
            #1;
            if ((out_valid & out_ready) != 4'b0000) acc++;
            rdy_s = flit_in_ready;
            @(posedge clk);
            if (flit_in_valid && rdy_s) n++;
            @(negedge clk);
        end
        check("midpkt_accepts", 64'(acc), 64'd3);
        flit_in_valid = 1'b0;
        #1;
        check("midpkt_busy_before", {63'd0, busy}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midpkt_reset", obs(flit_in_ready, out_valid, busy, err_hdr, pkt_count, out_flit),
              obs(1'b1, 4'b0000, 1'b0, 1'b0, 16'd0, 8'h00));
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Part 4: random traffic checked against the model. It starts from the
        // fresh post-reset state.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       e_rdy;
            logic [3:0] e_val;
            logic       e_err;
            logic [7:0] e_flit;
            logic [7:0] hd;
            logic       mpop;

            if (src.size() == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (b[7:2] == 6'h3F) b[7] = 1'b0;
                    src.push_back(b);
                end else begin
                    src.push_back({6'h3F, 2'($urandom_range(0, 3))});
                    repeat (5) begin
                        int r;
                        r = $urandom_range(0, 3);
                        if (r == 0)      src.push_back(8'hFF);
                        else if (r == 1) src.push_back({6'h3F, 2'($urandom_range(0, 3))});
                        else             src.push_back(8'($urandom));
                    end
                end
            end
            flit_in_valid = ($urandom_range(0, 3) != 0);
            flit_in       = src[0];
            out_ready     = 4'($urandom);
            #1;

            // Expected outputs from the model
            e_rdy  = (m_fifo.size() < 8);
            e_val  = 4'b0000;
            e_err  = 1'b0;
            e_flit = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
            if (m_fifo.size() > 0) begin
                if (m_in_pkt)                   e_val = 4'b0001 << m_port;
                else if (e_flit[7:2] == 6'h3F)  e_val = 4'b0001 << e_flit[1:0];
                else                            e_err = 1'b1;
            end
            check($sformatf("rand%0d", cyc),
                  obs(flit_in_ready, out_valid, busy, err_hdr, pkt_count, out_flit),
                  obs(e_rdy, e_val, m_in_pkt, e_err, m_pkt, e_flit));
            rdy_s = flit_in_ready;
            @(posedge clk);

            // Advance the model over the edge
            mpop = e_err || ((e_val & out_ready) != 4'b0000);
            if (mpop) begin
                hd = m_fifo.pop_front();
                if (!e_err) begin
                    if (!m_in_pkt) begin
                        m_in_pkt = 1;
                        m_port   = hd[1:0];
                        m_idx    = 1;
                    end else begin
                        m_idx++;
                        if (m_idx == 6) begin
                            m_in_pkt = 0;
                            m_idx    = 0;
                            m_pkt    = m_pkt + 16'd1;
                        end
                    end
                end
            end
            if (flit_in_valid && e_rdy) m_fifo.push_back(flit_in);
            if (flit_in_valid && rdy_s) void'(src.pop_front());
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
